lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Shares the single LCD write engine between two requesters: the refresh sequencer (port 0) and the status/alarm message writer (port 1).
//  Each requester posts a 6-bit transaction descriptor.
//  The arbiter grants one requester, drives the descriptor onto the engine's command inputs and runs the lcd_enable handshake.
//  It watches for lcd_finish, and aborts any transfer that hangs past a watchdog limit.
// PARAMETERS
//  TIMEOUT_MS  50  max clk_1ms cycles in RUN waiting for lcd_finish before abort (>=2)
//  ERR_W       4   width of saturating abort counter
// PORTS
//  clk_1ms     in   1      1 kHz system clock, all logic on rising edge
//  reset       in   1      asynchronous, active-high
//  req         in   2      req[i] level request; held until done[i] or timeout[i]
//  desc0       in   6      requester 0 descriptor {data_sel,DB_sel,reg_sel,mode,lcd_cnt[1:0]}
//  desc1       in   6      requester 1 descriptor, same packing
//  grant       out  2      one-hot owner of LCD engine, 0 when idle
//  done        out  2      1-cycle pulse: transfer of requester i completed
//  timeout     out  2      1-cycle pulse: transfer of requester i aborted by watchdog
//  lcd_finish  in   1      LCD engine completion strobe
//  lcd_enable  out  1      engine run, active-low (1 = hold/idle, 0 = run)
//  lcd_cnt     out  2      engine item count minus one
//  mode        out  1      1 = INIT table, 0 = REFRESH data
//  reg_sel     out  1      LCD RS line select
//  DB_sel      out  1      data-bus source select
//  data_sel    out  1      data source select
//  err_flag    out  1      sticky: at least one abort since reset
//  err_cnt     out  ERR_W  number of aborts, saturates at all-ones
// BEHAVIOUR
//  Reset (async): state IDLE.
//   - Engine outputs: lcd_enable=1, lcd_cnt=3, mode=1, reg_sel=0, DB_sel=1, data_sel=0.
//   - Handshake/status: grant=0, done=0, timeout=0, err_flag=0, err_cnt=0.
//   - Arbitration: last_owner=1, so port 0 wins the first tie.
//  Reset mid-transfer drops the transfer silently: no done, no timeout.
//  All outputs are registered.
//  FSM states: IDLE, SETUP, RUN, DONE, ABORT.
//  IDLE:
//   - req==0: stay; engine outputs hold their last values; lcd_enable=1.
//   - One req set: that port wins.
//   - Both set: round-robin, the port != last_owner wins.
//   - Next edge: grant[w]=1, descriptor of w latched into engine outputs, lcd_enable=1, go SETUP.
//  SETUP (1 cycle, setup time for engine):
//   - Next edge: lcd_enable=0, watchdog counter=0, go RUN.
//  RUN:
//   - Counter increments each cycle; lcd_enable stays 0.
//   - lcd_finish=1: next edge lcd_enable=1, done[w]=1, grant=0, last_owner=w, go DONE.
//   - Else counter==TIMEOUT_MS-1: next edge lcd_enable=1, timeout[w]=1, grant=0, last_owner=w.
//     Also err_flag=1 and err_cnt+1 (saturating); go ABORT.
//   - lcd_finish wins if it coincides with the final watchdog cycle.
//  DONE / ABORT (1 cycle):
//   - done/timeout pulse visible; next edge clears it, go IDLE.
//   - Minimum gap between transfers: DONE + IDLE = 2 cycles with lcd_enable=1.
//  Descriptor is sampled only on the IDLE->SETUP edge; later desc changes are ignored until the next grant.
//  req[w] dropped while granted: the transfer still completes normally and done/timeout still pulses.
//  lcd_finish outside RUN is ignored.
//  A requester re-asserting req immediately after done competes normally; round-robin prevents starvation.
//  grant is always one-hot or zero; never both bits set.
// TESTING
//  1. After reset, req=01, desc0=6'b0_1_0_1_11 -> SETUP grant=01, lcd_cnt=3, mode=1, DB_sel=1; RUN lcd_enable=0; finish -> done=01 one cycle.
//  2. req=11 continuously, finish 3 cycles into every RUN -> grants alternate 01,10,01,10; each done matches its grant.
//  3. req=10, lcd_finish never asserted -> lcd_enable low exactly 50 cycles; timeout=10 pulse; err_flag=1, err_cnt=1.
//  4. Force 16 aborts, ERR_W=4 -> err_cnt sticks at 15; err_flag stays 1 until reset.
//  5. Reset asserted mid-RUN -> lcd_enable=1 and grant=0 immediately (async); no done/timeout pulse follows.
//  6. lcd_finish on cycle TIMEOUT_MS-1 of RUN -> done pulses, no timeout, err_cnt unchanged.
//     Change desc0 during RUN -> lcd_cnt/mode/reg_sel unchanged until next grant.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one LCD write engine between the refresh sequencer (port 0)
// and the status/alarm writer (port 1), with round-robin arbitration and a RUN watchdog.
module lcd_bus_arbiter #(
  parameter int TIMEOUT_MS = 50,
  parameter int ERR_W      = 4
) (
  input  logic             clk_1ms,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [5:0]       desc0,
  input  logic [5:0]       desc1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic [1:0]       timeout,
  input  logic             lcd_finish,
  output logic             lcd_enable,
  output logic [1:0]       lcd_cnt,
  output logic             mode,
  output logic             reg_sel,
  output logic             DB_sel,
  output logic             data_sel,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int              WD_W     = $clog2(TIMEOUT_MS);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_MS - 1);
  localparam logic [5:0]      DESC_RST = 6'b010111;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DONE, S_ABORT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       timeout_q, timeout_d;
  logic             lcd_enable_q, lcd_enable_d;
  logic [5:0]       desc_q, desc_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             win_s;

  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // On a tie the port that did not own the engine last time wins.
  always_comb begin
    if (req == 2'b11) begin
      win_s = ~last_owner_q;
    end else begin
      win_s = req[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = 2'b00;
    timeout_d    = 2'b00;
    lcd_enable_d = lcd_enable_q;
    desc_d       = desc_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wd_d         = wd_q;
    err_flag_d   = err_flag_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        lcd_enable_d = 1'b1;
        if (req != 2'b00) begin
          owner_d = win_s;
          grant_d = port_onehot(win_s);
          desc_d  = win_s ? desc1 : desc0;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        lcd_enable_d = 1'b0;
        wd_d         = '0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + WD_W'(1);
        // Completion takes priority over the watchdog on its last cycle.
        if (lcd_finish) begin
          lcd_enable_d = 1'b1;
          done_d       = port_onehot(owner_q);
          grant_d      = 2'b00;
          last_owner_d = owner_q;
          state_d      = S_DONE;
        end else if (wd_q == WD_LAST) begin
          lcd_enable_d = 1'b1;
          timeout_d    = port_onehot(owner_q);
          grant_d      = 2'b00;
          last_owner_d = owner_q;
          err_flag_d   = 1'b1;
          if (err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end else begin
            err_cnt_d = err_cnt_q;
          end
          state_d = S_ABORT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: begin
        state_d      = S_IDLE;
        grant_d      = 2'b00;
        lcd_enable_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      done_q       <= 2'b00;
      timeout_q    <= 2'b00;
      lcd_enable_q <= 1'b1;
      desc_q       <= DESC_RST;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wd_q         <= '0;
      err_flag_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      lcd_enable_q <= lcd_enable_d;
      desc_q       <= desc_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
      err_flag_q   <= err_flag_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign lcd_enable = lcd_enable_q;
  assign data_sel   = desc_q[5];
  assign DB_sel     = desc_q[4];
  assign reg_sel    = desc_q[3];
  assign mode       = desc_q[2];
  assign lcd_cnt    = desc_q[1:0];
  assign err_flag   = err_flag_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Testbench for lcd_bus_arbiter: directed and randomized transfers checked against a
// transaction-level model of arbitration, RUN length, pulses and the abort counter.
module tb_lcd_bus_arbiter;

  localparam int TO     = 50;
  localparam int EW     = 4;
  localparam int ERRMAX = (1 << EW) - 1;

  logic          clk_1ms = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [5:0]    desc0, desc1;
  logic [1:0]    grant, done, timeout;
  logic          lcd_finish, lcd_enable;
  logic [1:0]    lcd_cnt;
  logic          mode, reg_sel, DB_sel, data_sel, err_flag;
  logic [EW-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_last = 1;
  int m_errs = 0;
  int m_flag = 0;

  lcd_bus_arbiter #(.TIMEOUT_MS(TO), .ERR_W(EW)) dut (
    .clk_1ms(clk_1ms), .reset(reset), .req(req), .desc0(desc0), .desc1(desc1),
    .grant(grant), .done(done), .timeout(timeout), .lcd_finish(lcd_finish),
    .lcd_enable(lcd_enable), .lcd_cnt(lcd_cnt), .mode(mode), .reg_sel(reg_sel),
    .DB_sel(DB_sel), .data_sel(data_sel), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  always #5 clk_1ms = ~clk_1ms;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=still running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Owner chosen from the request pair and the previous owner.
  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return r[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  // Full transfer starting at a negedge with the DUT in IDLE; ends at the following IDLE negedge.
  task automatic xfer(input logic [1:0] r, input int fin_at, input bit drop,
                      input logic [5:0] d0, input logic [5:0] d1);
    int         w, low, exp_low;
    bit         aborted;
    logic [5:0] d;
    logic [1:0] oh;
    desc0 = d0;
    desc1 = d1;
    req = r;
    lcd_finish = 1'($urandom_range(0, 1));
    w  = pick(r, m_last);
    d  = (w == 1) ? d1 : d0;
    oh = onehot(w);
    @(negedge clk_1ms);
    check("setup_grant", 32'(grant), 32'(oh));
    check("setup_enable", 32'(lcd_enable), 32'd1);
    check("setup_desc", 32'({data_sel, DB_sel, reg_sel, mode, lcd_cnt}), 32'(d));
    desc0 = 6'($urandom);
    desc1 = 6'($urandom);
    lcd_finish = 1'($urandom_range(0, 1));
    if (drop) req = 2'b00;
    @(negedge clk_1ms);
    low = 0;
    while (lcd_enable === 1'b0 && low < TO + 5) begin
      low++;
      check("run_grant", 32'(grant), 32'(oh));
      lcd_finish = (low - 1 == fin_at);
      @(negedge clk_1ms);
    end
    lcd_finish = 1'b0;
    aborted = !(fin_at >= 0 && fin_at < TO);
    exp_low = aborted ? TO : fin_at + 1;
    if (aborted) begin
      m_flag = 1;
      if (m_errs < ERRMAX) m_errs++;
    end
    m_last = w;
    check("run_length", 32'(low), 32'(exp_low));
    check("end_done", 32'(done), aborted ? 32'd0 : 32'(oh));
    check("end_timeout", 32'(timeout), aborted ? 32'(oh) : 32'd0);
    check("end_grant", 32'(grant), 32'd0);
    check("end_err_flag", 32'(err_flag), 32'(m_flag));
    check("end_err_cnt", 32'(err_cnt), 32'(m_errs));
    check("end_desc_held", 32'({data_sel, DB_sel, reg_sel, mode, lcd_cnt}), 32'(d));
    @(negedge clk_1ms);
    check("gap_pulses", 32'({done, timeout}), 32'd0);
    check("gap_enable", 32'(lcd_enable), 32'd1);
    check("gap_grant", 32'(grant), 32'd0);
    req = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 2'b00;
    lcd_finish = 1'b0;
    @(negedge clk_1ms);
    reset = 1'b0;
    m_last = 1;
    m_errs = 0;
    m_flag = 0;
    @(negedge clk_1ms);
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00;
    desc0 = 6'd0;
    desc1 = 6'd0;
    lcd_finish = 1'b0;
    repeat (2) @(negedge clk_1ms);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_pulses", 32'({done, timeout}), 32'd0);
    check("rst_enable", 32'(lcd_enable), 32'd1);
    check("rst_engine", 32'({data_sel, DB_sel, reg_sel, mode, lcd_cnt}), 32'h17);
    check("rst_err", 32'({err_flag, err_cnt}), 32'd0);
    reset = 1'b0;
    @(negedge clk_1ms);

    // Single requester 0, finish early.
    xfer(2'b01, 3, 1'b0, 6'b010111, 6'($urandom));
    xfer(2'b01, 0, 1'b0, 6'b101000, 6'($urandom));

    // Continuous tie: grants alternate starting with port 0 after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("rr_expected", 32'(pick(2'b11, m_last)), 32'(i % 2));
      xfer(2'b11, 2, 1'b0, 6'($urandom), 6'($urandom));
    end

    // Watchdog abort, then enough aborts to saturate the counter.
    xfer(2'b10, -1, 1'b0, 6'($urandom), 6'($urandom));
    for (int i = 0; i < 16; i++) begin
      xfer(2'($urandom_range(1, 3)), -1, 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom));
    end

    // Finish on the final watchdog cycle beats the abort.
    xfer(2'b01, TO - 1, 1'b0, 6'($urandom), 6'($urandom));
    xfer(2'b10, TO - 2, 1'b1, 6'($urandom), 6'($urandom));

    // Randomized transfers.
    for (int i = 0; i < 25; i++) begin
      xfer(2'($urandom_range(1, 3)), int'($urandom_range(0, TO + 10)),
           1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom));
    end

    // Asynchronous reset in the middle of RUN drops the transfer silently.
    req = 2'b01;
    repeat (5) @(negedge clk_1ms);
    check("pre_reset_enable", 32'(lcd_enable), 32'd0);
    reset = 1'b1;
    #1;
    check("async_enable", 32'(lcd_enable), 32'd1);
    check("async_grant", 32'(grant), 32'd0);
    check("async_err", 32'({err_flag, err_cnt}), 32'd0);
    @(negedge clk_1ms);
    req = 2'b00;
    reset = 1'b0;
    m_last = 1;
    m_errs = 0;
    m_flag = 0;
    for (int i = 0; i < TO + 5; i++) begin
      @(negedge clk_1ms);
      if (i % 10 == 0) check("post_reset_quiet", 32'({done, timeout, grant, lcd_enable}), 32'd1);
    end
    xfer(2'b11, 5, 1'b0, 6'($urandom), 6'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
